fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Prefetch buffer between the instruction memory and the IF/ID pipeline register. It owns the fetch PC and issues word fetches under a req/valid handshake. Returned instructions are queued with their PC, and the head entry is presented to IF/ID. A branch or flush from the condition handler discards queued and in-flight instructions and redirects fetch to the target address.

Parameters:
DEPTH, 4, queue entries (power of 2, ≥2)
ADDR_W, 32, PC / fetch address width
DATA_W, 32, instruction width
RESET_PC, 0, fetch address after reset

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
imem_req  out  1  fetch request, held until imem_valid
imem_addr  out  ADDR_W  fetch address, stable while imem_req=1
imem_valid  in  1  response valid; legal only while imem_req=1
imem_data  in  DATA_W  instruction word, qualified by imem_valid
flush  in  1  redirect (taken branch / BL)
flush_target  in  ADDR_W  new fetch address, sampled when flush=1
deq_en  in  1  IF/ID consumes head entry (driven by IF_ID enable)
out_valid  out  1  head entry present
out_instr  out  DATA_W  head instruction; 0 when empty
out_pc  out  ADDR_W  address of head instruction; 0 when empty
out_next_pc  out  ADDR_W  out_pc+4 when valid; 0 when empty
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (sync, dominates all inputs): state=IDLE, fetch_pc=RESET_PC, count=0, rd/wr ptr=0, imem_req=0, out_valid=0, out_instr/out_pc/out_next_pc=0.
- Outputs are combinational from registered state only: imem_req=1 in WAIT and DROP; imem_addr=fetch_pc. The head outputs come from the queue head.
- One outstanding request at most. Addresses step by 4 and wrap modulo 2^ADDR_W.
- FSM IDLE:
  - flush → fetch_pc=flush_target, count=0, stay IDLE.
  - else if count − deq_accept < DEPTH → WAIT.
- FSM WAIT:
  - flush & imem_valid → drop the response, count=0, fetch_pc=flush_target, stay WAIT.
  - flush & !imem_valid → fetch_pc_pending=flush_target, count=0, go DROP. imem_addr keeps the old address.
  - imem_valid & !flush → enqueue {imem_data, fetch_pc}, fetch_pc+=4.
    - If (count+1−deq_accept) < DEPTH, stay WAIT; this allows back-to-back fetches, one per cycle with a zero-wait memory.
    - Else go IDLE.
- FSM DROP:
  - imem_valid → discard the response, fetch_pc=fetch_pc_pending, go WAIT.
  - flush → update fetch_pc_pending=flush_target, stay DROP.
  - The queue remains empty while in DROP.
- deq_accept = deq_en & out_valid & !flush. deq_en while empty is ignored, with no underflow.
- Simultaneous enqueue+dequeue: count unchanged, both pointers advance.
- Overflow is impossible by construction, because a request is issued only with a free slot guaranteed. Assert count≤DEPTH.
- Pointer wrap at DEPTH. A full queue is count==DEPTH.
- Latency: an instruction is visible at out_* in the cycle after its imem_valid. With a zero-wait memory, the first out_valid comes in the 3rd cycle after reset deassertion.

Decomposition:
- Package fetch_pkg: FSM enum {IDLE, WAIT, DROP}, PC_STEP=4, NOP_INSTR=32'h0, and the entry struct/width {instr, pc}.
- One sub-module, fq_sync_fifo (DEPTH × (DATA_W+ADDR_W)).
  - Ports: push, pop, clr, count.
  - clr has priority over push/pop.
- The FSM and PC logic stay in fetch_queue.

Test Plan:
- Reset then zero-wait memory (imem_valid=imem_req, data=addr^32'hA5A5_0000), deq_en=1 → out_pc sequence 0,4,8,12… one per cycle from cycle 3; out_next_pc=out_pc+4; count ≤1.
- deq_en=0, zero-wait memory → exactly 4 enqueues (pc 0..12), count=4, then FSM in IDLE with imem_req=0. Set deq_en=1 for one cycle → one new fetch at addr 16.
- 3-cycle memory latency, flush with target 0x40 in the 2nd wait cycle → the in-flight response at old address is discarded, out_valid=0 until the instruction at 0x40 arrives, then 0x44.
- Flush together with imem_valid and deq_en → no enqueue, no dequeue, count=0, next imem_addr=flush_target.
- Back-to-back flushes (0x80 then 0xC0) while in DROP → first valid output pc=0xC0.
- deq_en=1 while empty plus reset asserted mid-stream with count=3 → no underflow; the cycle after reset gives count=0, imem_req=0, out_*=0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared FSM states, constants and entry layout for the fetch queue
package fetch_pkg;

    // Fetch FSM: IDLE = no request, WAIT = request outstanding,
    // DROP = request outstanding whose response must be discarded.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fq_state_t;

    localparam int unsigned PC_STEP   = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0;

    // Queue entry for the default 32/32 configuration; the FIFO stores {instr, pc}.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fq_entry_t;

    localparam int unsigned ENTRY_W = $bits(fq_entry_t);

endpackage

// File: rtl/fq_sync_fifo.sv
// rtl/fq_sync_fifo.sv - synchronous FIFO with clear, holding {instr, pc} fetch entries
module fq_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Pop from empty is ignored; push into full is only allowed alongside a pop.
    assign w_pop     = pop && (r_count != '0);
    assign w_push    = push && ((r_count != FULL) || w_pop);
    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Pointers and occupancy; clear wins over push/pop, pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    // Storage array; contents need no reset since count qualifies them.
    always_ff @(posedge clk) begin
        if (!reset && !clr && w_push) r_mem[r_wr_ptr] <= push_data;
    end

    // Occupancy can never exceed the array size.
    always_ff @(posedge clk) begin
        if (!reset) assert (r_count <= FULL);
    end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue owning the fetch PC, with flush redirect
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic                       imem_valid,
    input  logic [DATA_W-1:0]          imem_data,
    input  logic                       flush,
    input  logic [ADDR_W-1:0]          flush_target,
    input  logic                       deq_en,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [ADDR_W-1:0]          out_next_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int                CW      = $clog2(DEPTH + 1);
    localparam int                EW      = DATA_W + ADDR_W;
    localparam logic [CW:0]       DEPTH_X = (CW + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);

    fq_state_t         r_state;
    fq_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] w_fetch_pc_nxt;
    logic [ADDR_W-1:0] r_pend_pc;
    logic [ADDR_W-1:0] w_pend_pc_nxt;
    logic [CW-1:0]     w_count;
    logic [EW-1:0]     w_head;
    logic              w_has_head;
    logic              w_deq;
    logic              w_push;
    logic              w_room_idle;
    logic              w_room_wait;

    assign w_has_head = (w_count != '0);
    assign w_deq      = deq_en && w_has_head && !flush;

    // A new request is only launched when its response is guaranteed a free slot.
    assign w_room_idle = (({1'b0, w_count} - {{CW{1'b0}}, w_deq}) < DEPTH_X);
    assign w_room_wait = (({1'b0, w_count} + (CW + 1)'(1) - {{CW{1'b0}}, w_deq}) < DEPTH_X);

    fq_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clr       (flush),
        .push      (w_push),
        .push_data ({imem_data, r_fetch_pc}),
        .pop       (w_deq),
        .head_data (w_head),
        .count     (w_count)
    );

    // Next-state and fetch/pending PC selection for the one-outstanding-request fetcher.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_pend_pc_nxt  = r_pend_pc;
        w_push         = 1'b0;
        case (r_state)
            IDLE: begin
                if (flush)            w_fetch_pc_nxt = flush_target;
                else if (w_room_idle) w_state_nxt    = WAIT;
            end
            WAIT: begin
                if (flush) begin
                    if (imem_valid) begin
                        w_fetch_pc_nxt = flush_target;
                    end else begin
                        // Address must stay stable until the old response returns.
                        w_pend_pc_nxt = flush_target;
                        w_state_nxt   = DROP;
                    end
                end else if (imem_valid) begin
                    w_push         = 1'b1;
                    w_fetch_pc_nxt = r_fetch_pc + STEP;
                    if (!w_room_wait) w_state_nxt = IDLE;
                end
            end
            DROP: begin
                if (imem_valid) begin
                    w_fetch_pc_nxt = flush ? flush_target : r_pend_pc;
                    w_state_nxt    = WAIT;
                end else if (flush) begin
                    w_pend_pc_nxt = flush_target;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and PC registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
        end
    end

    assign imem_req    = (r_state == WAIT) || (r_state == DROP);
    assign imem_addr   = r_fetch_pc;
    assign out_valid   = w_has_head;
    assign out_instr   = w_has_head ? w_head[EW-1:ADDR_W] : DATA_W'(NOP_INSTR);
    assign out_pc      = w_has_head ? w_head[ADDR_W-1:0] : '0;
    assign out_next_pc = w_has_head ? (w_head[ADDR_W-1:0] + STEP) : '0;
    assign count       = w_count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue with randomized memory and flushes
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_valid = 1'b0;
    logic [31:0]   imem_data = 32'h0;
    logic          flush = 1'b0;
    logic [31:0]   flush_target = 32'h0;
    logic          deq_en = 1'b0;
    logic          out_valid;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic [31:0]   out_next_pc;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_data    (imem_data),
        .flush        (flush),
        .flush_target (flush_target),
        .deq_en       (deq_en),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_next_pc  (out_next_pc),
        .count        (count)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: queue of PCs the buffer should hold, plus the memory-side request view.
    logic [31:0] exp_q[$];
    bit          mon_en = 1'b0;
    bit          in_flight = 1'b0;
    bit          stale = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] exp_fetch = 32'h0;
    int          lat = 0;
    int          lat_lo = 0;
    int          lat_hi = 0;
    int          idle_run = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare presented head/count against the model every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                chk("out_valid", 32'(out_valid), 32'd1);
                chk("out_pc", out_pc, exp_q[0]);
                chk("out_instr", out_instr, mem_word(exp_q[0]));
                chk("out_next_pc", out_next_pc, 32'(exp_q[0] + 32'd4));
            end else begin
                chk("out_valid_empty", 32'(out_valid), 32'd0);
                chk("out_pc_empty", out_pc, 32'd0);
                chk("out_instr_empty", out_instr, 32'd0);
                chk("out_next_pc_empty", out_next_pc, 32'd0);
            end
            chk("count", 32'(count), 32'(exp_q.size()));
            if (imem_req) chk("req_needs_room", 32'(count < DEPTH), 32'd1);
            if (in_flight) begin
                chk("req_held", 32'(imem_req), 32'd1);
                chk("addr_held", imem_addr, req_addr);
            end
            if (!imem_req && count < DEPTH && !flush && !reset) idle_run++;
            else idle_run = 0;
            if (idle_run > 0) chk("fetch_stall", 32'(idle_run <= 3), 32'd1);
        end
    end

    // One cycle of stimulus plus a memory with per-request latency; updates the model.
    task automatic step(input bit f, input logic [31:0] tgt, input bit d, input bit r);
        bit v;
        bit ok;
        @(negedge clk);
        #1;
        reset = r; flush = f; flush_target = tgt; deq_en = d;
        v = 1'b0; ok = 1'b0;
        if (!r && imem_req && !in_flight) begin
            chk("fetch_addr", imem_addr, exp_fetch);
            in_flight = 1'b1; req_addr = imem_addr; stale = 1'b0;
            lat = $urandom_range(lat_hi, lat_lo);
        end
        if (!r && in_flight) begin
            if (lat == 0) v = 1'b1;
            else lat--;
        end
        imem_valid = v;
        imem_data  = v ? mem_word(req_addr) : 32'h0;
        if (r) begin
            exp_q.delete(); in_flight = 1'b0; stale = 1'b0; exp_fetch = 32'h0;
        end else begin
            if (v) begin
                ok = !stale && !f;
                in_flight = 1'b0;
                if (ok) exp_fetch = req_addr + 32'd4;
            end else if (in_flight && f) begin
                stale = 1'b1;
            end
            if (f) begin
                exp_q.delete();
                exp_fetch = tgt;
            end else begin
                if (d && exp_q.size() > 0) void'(exp_q.pop_front());
                if (ok) exp_q.push_back(req_addr);
            end
        end
    endtask

    task automatic first_valid(input string nm, input logic [31:0] pc);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            step(1'b0, 32'h0, 1'b0, 1'b0);
            n++;
        end
        chk(nm, out_valid ? out_pc : 32'hDEAD_BEEF, pc);
    endtask

    initial begin
        bit f, d, r;
        logic [31:0] tgt;

        // Zero-wait memory, continuous dequeue: first valid in 3rd cycle, then one per cycle.
        step(1'b0, 32'h0, 1'b0, 1'b1);
        mon_en = 1'b1;
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("lat_req0", 32'(imem_req), 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("lat_req1", 32'(imem_req), 32'd1);
        chk("lat_valid0", 32'(out_valid), 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("lat_valid1", 32'(out_valid), 32'd1);
        chk("lat_pc0", out_pc, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_pc", out_pc, 32'(4 * k));
            chk("stream_count", 32'(count <= 1), 32'd1);
        end

        // No dequeue: exactly DEPTH fetches then idle; one dequeue releases fetch at 16.
        step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_req", 32'(imem_req), 32'd0);
        chk("full_addr", imem_addr, 32'd16);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("refetch_req", 32'(imem_req), 32'd1);
        chk("refetch_addr", imem_addr, 32'd16);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // 3-cycle memory, flush to 0x40 in the second wait cycle.
        lat_lo = 3; lat_hi = 3;
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h40, 1'b1, 1'b0);
        first_valid("flush_first_pc", 32'h40);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        first_valid("flush_second_pc", 32'h44);

        // Flush coinciding with imem_valid and deq_en.
        lat_lo = 0; lat_hi = 0;
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("fv_pre_req", 32'(imem_req), 32'd1);
        step(1'b1, 32'h100, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("fv_count", 32'(count), 32'd0);
        chk("fv_addr", imem_addr, 32'h100);

        // Back-to-back flushes while dropping.
        lat_lo = 3; lat_hi = 3;
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h80, 1'b0, 1'b0);
        step(1'b1, 32'hC0, 1'b0, 1'b0);
        first_valid("dbl_flush_pc", 32'hC0);

        // Dequeue while empty, then reset mid-stream with three entries queued.
        step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 1'b1, 1'b0);
        lat_lo = 0; lat_hi = 0;
        begin
            int n;
            n = 0;
            while (count != 3 && n < 20) begin
                step(1'b0, 32'h0, 1'b0, 1'b0);
                n++;
            end
        end
        chk("fill3", 32'(count), 32'd3);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst_restart_req", 32'(imem_req), 32'd1);
        chk("rst_restart_addr", imem_addr, 32'd0);

        // Randomized traffic, including targets that wrap the address space.
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) begin
                lat_lo = 0;
                lat_hi = $urandom_range(3, 0);
            end
            f   = ($urandom_range(15, 0) == 0);
            tgt = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            d   = ($urandom_range(2, 0) != 0);
            r   = ($urandom_range(299, 0) == 0);
            step(f, tgt, d, r);
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
